// File: rtl/cdb_pkg.sv
// Shared CDB geometry and lane bit-packing helpers.
// Lane 0 occupies the most significant slot of every flat CDB bus.
package cdb_pkg;

  localparam int CDB_LANES  = 4;
  localparam int CDB_IDX_W  = 4;
  localparam int CDB_DATA_W = 16;

  function automatic int lane_slot(input int lanes, input int k);
    return lanes - 1 - k;
  endfunction

  function automatic int lane_lsb(input int lanes, input int k,
                                  input int w);
    return (lanes - 1 - k) * w;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant: picks up to N_LANES held requesters
// starting at rr_ptr and packs them onto lanes from lane 0.
module rr_multi_grant #(
  parameter int N_REQ   = 6,
  parameter int N_LANES = 4,
  parameter int PTR_W   = $clog2(N_REQ),
  parameter int LANE_W  = $clog2(N_LANES)
) (
  input  logic [N_REQ-1:0]              held,
  input  logic [PTR_W-1:0]              rr_ptr,
  output logic [N_REQ-1:0]              grant,
  output logic [N_LANES-1:0]            lane_valid,
  output logic [N_LANES-1:0][PTR_W-1:0] lane_src,
  output logic [PTR_W-1:0]              rr_ptr_next
);

  logic [LANE_W:0] cnt;
  logic [PTR_W:0]  sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant       = '0;
    lane_valid  = '0;
    lane_src    = '0;
    rr_ptr_next = rr_ptr;
    cnt         = '0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ))
        sum = sum - (PTR_W+1)'(N_REQ);
      idx = sum[PTR_W-1:0];
      if (held[idx] && (cnt < (LANE_W+1)'(N_LANES))) begin
        grant[idx]                  = 1'b1;
        lane_valid[cnt[LANE_W-1:0]] = 1'b1;
        lane_src[cnt[LANE_W-1:0]]   = idx;
        rr_ptr_next = (idx == PTR_W'(N_REQ-1)) ? '0 : idx + 1'b1;
        cnt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-unit holding buffers feeding a registered multi-lane CDB
// through a round-robin multi-grant arbiter.
import cdb_pkg::*;

module cdb_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_LANES = cdb_pkg::CDB_LANES,
  parameter int IDX_W     = cdb_pkg::CDB_IDX_W,
  parameter int DATA_W    = cdb_pkg::CDB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]    req_rob_index_flat,
  input  logic [NUM_REQ*DATA_W-1:0]   req_result_flat,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_LANES-1:0]        cdb_valid_flat,
  output logic [NUM_LANES*IDX_W-1:0]  cdb_rob_index_flat,
  output logic [NUM_LANES*DATA_W-1:0] cdb_result_flat
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              held_q, held_d;
  logic [NUM_REQ-1:0][IDX_W-1:0]   held_idx_q, held_idx_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]  held_data_q, held_data_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0]            cdb_valid_q, cdb_valid_d;
  logic [NUM_LANES-1:0][IDX_W-1:0] cdb_idx_q, cdb_idx_d;
  logic [NUM_LANES-1:0][DATA_W-1:0] cdb_data_q, cdb_data_d;

  logic [NUM_REQ-1:0]              grant;
  logic [NUM_LANES-1:0]            lane_valid;
  logic [NUM_LANES-1:0][PTR_W-1:0] lane_src;
  logic [PTR_W-1:0]                rr_ptr_next;
  logic [NUM_REQ-1:0][IDX_W-1:0]   req_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;

  rr_multi_grant #(
    .N_REQ   (NUM_REQ),
    .N_LANES (NUM_LANES),
    .PTR_W   (PTR_W)
  ) u_rr (
    .held        (held_q),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .lane_valid  (lane_valid),
    .lane_src    (lane_src),
    .rr_ptr_next (rr_ptr_next)
  );

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign req_idx[r]  = req_rob_index_flat[r*IDX_W +: IDX_W];
    assign req_data[r] = req_result_flat[r*DATA_W +: DATA_W];
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign cdb_valid_flat[lane_slot(NUM_LANES, k)] = cdb_valid_q[k];
    assign cdb_rob_index_flat[lane_lsb(NUM_LANES, k, IDX_W) +: IDX_W] =
      cdb_idx_q[k];
    assign cdb_result_flat[lane_lsb(NUM_LANES, k, DATA_W) +: DATA_W] =
      cdb_data_q[k];
  end

  // A buffer being granted this cycle can take its successor at once.
  assign req_ready = (~held_q | grant) & {NUM_REQ{~rst & ~flush}};

  always_comb begin
    held_d      = held_q & ~grant;
    held_idx_d  = held_idx_q;
    held_data_d = held_data_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        held_d[r]      = 1'b1;
        held_idx_d[r]  = req_idx[r];
        held_data_d[r] = req_data[r];
      end
    end
    if (flush)
      held_d = '0;
    rr_ptr_d = flush ? rr_ptr_q : rr_ptr_next;
    for (int k = 0; k < NUM_LANES; k++) begin
      cdb_valid_d[k] = lane_valid[k] & ~flush;
      cdb_idx_d[k]   = cdb_valid_d[k] ? held_idx_q[lane_src[k]]  : '0;
      cdb_data_d[k]  = cdb_valid_d[k] ? held_data_q[lane_src[k]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q      <= '0;
      held_idx_q  <= '0;
      held_data_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_idx_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      held_q      <= held_d;
      held_idx_q  <= held_idx_d;
      held_data_q <= held_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_idx_q   <= cdb_idx_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completed results from up to six functional units onto the four-lane common data bus (CDB) consumed by the reservation stations and the ROB. Each functional unit gets a one-entry holding buffer. Every cycle, up to four held results are granted in round-robin order and driven onto registered CDB lanes. The block sits between the functional-unit writeback stages and every CDB listener, and provides per-unit backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 6: number of functional-unit requesters.
- `NUM_LANES`, default 4: number of CDB lanes.
- `IDX_W`, default 4: ROB index width.
- `DATA_W`, default 16: result width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `flush`  in  1  synchronous squash; drops every held result and every pending CDB output.
- `req_valid`  in  `NUM_REQ`  bit r: unit r presents a result.
- `req_rob_index_flat`  in  `NUM_REQ*IDX_W`  unit r at bits `[r*IDX_W +: IDX_W]`.
- `req_result_flat`  in  `NUM_REQ*DATA_W`  unit r at bits `[r*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`  bit r: the holding buffer of unit r can accept this cycle.
- `cdb_valid_flat`  out  `NUM_LANES`  lane k at bit `(NUM_LANES-1-k)`, so lane 0 is the MSB.
- `cdb_rob_index_flat`  out  `NUM_LANES*IDX_W`  lane k at `[(NUM_LANES-1-k)*IDX_W +: IDX_W]`.
- `cdb_result_flat`  out  `NUM_LANES*DATA_W`  lane k at `[(NUM_LANES-1-k)*DATA_W +: DATA_W]`.

## Operation
- Per-requester state: `held[r]`, `held_idx[r]`, `held_data[r]`. Arbiter state: round-robin pointer `rr_ptr`, with range 0..`NUM_REQ`-1.
- `req_ready[r] = ~rst & ~flush & (~held[r] | grant[r])`. This is combinational and does not depend on `req_valid`.
- Handshake: when `req_valid[r] & req_ready[r]` at an edge, the buffer loads and `held[r]` becomes 1. When granted and not reloaded, `held[r]` becomes 0. When granted and reloaded in the same cycle, `held[r]` stays 1 with the new payload.
- Grant selection (combinational, from `held` only):
  - Scan requesters `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - The first `NUM_LANES` held requesters are granted.
  - The i-th granted requester goes to lane i, so lanes fill from lane 0 with no gaps.
- Pointer update: if at least one grant occurs, `rr_ptr` becomes (index of last granted requester + 1) mod `NUM_REQ`. With no grants, `rr_ptr` is unchanged.
- CDB outputs are registered. At each edge, lane i loads the payload of the i-th grant and sets its valid bit to 1. Unused lanes load valid 0, index 0 and data 0.
- Every CDB output is valid for exactly one cycle. A result is never driven twice and never dropped except by `flush` or `rst`.
- `flush` (when `rst` is low):
  - At the edge, all `held` bits clear, all CDB valids clear, and no request is accepted.
  - `rr_ptr` is preserved.
  - Results already visible on the CDB in the flush cycle are not retracted.
- `rst` clears all `held` bits and `rr_ptr`. It zeroes all CDB outputs. `rst` has priority over `flush` and over any handshake.
- Duplicate ROB indices across requesters are passed through unchanged. Detecting them is not this block's job.

## Timing
- Reset values:
  - `cdb_valid_flat`, `cdb_rob_index_flat` and `cdb_result_flat` are all 0.
  - `req_ready` is 0 while `rst` is high and all-ones in the first cycle after reset.
- Latency:
  - Handshake at edge N.
  - Held during cycle N..N+1.
  - If granted, the CDB shows the result after edge N+1.
  - Minimum latency is 2 edges. There is no bypass path.
- Throughput: up to `NUM_LANES` results per cycle. One result per requester per cycle is sustained while that requester is granted every cycle.
- Fairness: a held requester is granted within `ceil(NUM_REQ/NUM_LANES)` = 2 cycles under full load.
- Mid-operation `rst`: in-flight entries are lost. A unit whose result was lost must be reset alongside this block.

## Structure
- Shared package `cdb_pkg`: `NUM_LANES`, `IDX_W`, `DATA_W` constants and the lane bit-packing helper functions. These are used by the reservation station, the ROB and this block alike.
- Sub-module `rr_multi_grant`: combinational; takes `held` and `rr_ptr`; produces the per-requester grant vector, a per-lane source index with lane-valid, and the next `rr_ptr`.
- The top level holds the buffers, the pointer register and the output registers.

## Test plan
- Reset then single request: unit 2 presents idx 5, data 0x1234 at edge 1.
  - After edge 2: lane 0 valid, idx 5, data 0x1234.
  - `cdb_valid_flat` = 4'b1000.
  - Next cycle: `cdb_valid_flat` = 0.
- Six simultaneous requests with `rr_ptr` = 0, held constant:
  - First CDB cycle: units 0–3 on lanes 0–3.
  - Next cycle: units 4 and 5 on lanes 0 and 1; `cdb_valid_flat` = 4'b1100.
  - `rr_ptr` ends at 0.
- Back-to-back on one unit: unit 1 asserts `req_valid` every cycle with idx 1, 2, 3.
  - `req_ready[1]` stays 1.
  - CDB lane 0 shows 1, 2, 3 on consecutive cycles.
- Backpressure with `req_valid` all-ones and `rr_ptr` = 4:
  - All six units are held.
  - `req_ready` for units 2 and 3 is 0 while they wait.
  - No entry is overwritten: every idx appears exactly once.
- Flush with three units held:
  - Assert `flush` for one cycle; `req_ready` = 0 that cycle.
  - The following two cycles show `cdb_valid_flat` = 0.
  - A new request afterwards appears normally.
- `rst` asserted while four units are held and lanes are valid:
  - After the edge, all outputs are 0 and `held` is empty.
  - No stale result appears after `rst` deasserts.
